// File: rtl/de_morgan_checker.sv
// rtl/de_morgan_checker.sv - on-chip stimulus/response checker for a two-input NAND-form De Morgan block
//
// Purpose: sweeps {a,b} over 00,01,10,11 for PASSES passes, holds each vector
// HOLD_CYCLES cycles, then samples y for one cycle and compares it with ~(a & b).
// Mismatches are counted (saturating) and the first failing vector is latched.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - run request, honoured only in IDLE or DONE
//   a, b      - stimulus to the block under check ({a,b} = current vector)
//   y         - response of the block under check (combinational from a,b)
//   busy      - run in progress (DRIVE or SAMPLE)
//   done      - run finished; results valid
//   pass      - valid with done: no mismatches this run
//   err_cnt   - saturating mismatch count
//   fail_seen - at least one mismatch this run
//   fail_vec  - {a,b} of the first mismatch this run
module de_morgan_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int PASSES      = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [1:0]       fail_vec
);

  // Counters are at least one bit wide so HOLD_CYCLES = 1 / PASSES = 1 still elaborate.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       vec, vec_nx;
  logic [HW-1:0]    hold, hold_nx;
  logic [PW-1:0]    pass_idx, pass_idx_nx;
  logic [CNT_W-1:0] err_nx;
  logic             fail_seen_nx;
  logic [1:0]       fail_vec_nx;
  logic             a_nx, b_nx, busy_nx, done_nx, pass_nx;

  always_comb begin
    state_nx     = state;
    vec_nx       = vec;
    hold_nx      = hold;
    pass_idx_nx  = pass_idx;
    err_nx       = err_cnt;
    fail_seen_nx = fail_seen;
    fail_vec_nx  = fail_vec;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx     = DRIVE;
          vec_nx       = 2'd0;
          hold_nx      = '0;
          pass_idx_nx  = '0;
          err_nx       = '0;
          fail_seen_nx = 1'b0;
          fail_vec_nx  = 2'd0;
        end
      end
      DRIVE: begin
        if (hold == HOLD_LAST) begin
          state_nx = SAMPLE;
        end else begin
          hold_nx = hold + 1'b1;
        end
      end
      SAMPLE: begin
        // a,b have been stable for HOLD_CYCLES cycles, so y has settled.
        if (y != ~(a & b)) begin
          if (err_cnt != '1) begin
            err_nx = err_cnt + 1'b1;
          end
          if (!fail_seen) begin
            fail_seen_nx = 1'b1;
            fail_vec_nx  = {a, b};
          end
        end
        if (vec == 2'd3 && pass_idx == PASS_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = DRIVE;
          vec_nx   = vec + 2'd1;
          hold_nx  = '0;
          if (vec == 2'd3) begin
            pass_idx_nx = pass_idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered: derive them from the next state so they line up
    // with the state they describe.
    busy_nx     = (state_nx == DRIVE) || (state_nx == SAMPLE);
    done_nx     = (state_nx == DONE);
    pass_nx     = done_nx && (err_nx == '0);
    {a_nx, b_nx} = busy_nx ? vec_nx : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      hold      <= '0;
      pass_idx  <= '0;
      err_cnt   <= '0;
      fail_seen <= 1'b0;
      fail_vec  <= 2'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nx;
      vec       <= vec_nx;
      hold      <= hold_nx;
      pass_idx  <= pass_idx_nx;
      err_cnt   <= err_nx;
      fail_seen <= fail_seen_nx;
      fail_vec  <= fail_vec_nx;
      a         <= a_nx;
      b         <= b_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
    end
  end

endmodule

// File: tb/tb_de_morgan_checker.sv
// tb/tb_de_morgan_checker.sv - self-checking bench for de_morgan_checker
module tb_de_morgan_checker;

  localparam int HOLD   = 4;
  localparam int NPASS  = 2;
  localparam int RUNLEN = NPASS * 4 * (HOLD + 1);
  localparam logic [3:0] GOOD_TT = 4'b0111; // truth table of ~(a&b), indexed by {a,b}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] tt = GOOD_TT;

  logic a0, b0, y0, busy0, done0, pass0, fs0;
  logic [7:0] err0;
  logic [1:0] fv0;
  logic a1, b1, y1, busy1, done1, pass1, fs1;
  logic [1:0] err1;
  logic [1:0] fv1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Block under check modelled as an arbitrary truth table.
  assign y0 = tt[{a0, b0}];
  assign y1 = tt[{a1, b1}];

  de_morgan_checker #(.HOLD_CYCLES(HOLD), .PASSES(NPASS), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_seen(fs0), .fail_vec(fv0)
  );

  de_morgan_checker #(.HOLD_CYCLES(HOLD), .PASSES(NPASS), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_seen(fs1), .fail_vec(fv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out0"}, {a0, b0, busy0, done0, pass0, fs0, fv0, err0}, 32'd0);
    chk({tag, "_out1"}, {a1, b1, busy1, done1, pass1, fs1, fv1, err1}, 32'd0);
  endtask

  // One full run with truth table t; the expected results come from counting
  // wrong truth-table entries, not from stepping a state machine.
  task automatic run(input logic [3:0] t, input bit hold_start, input string tag);
    logic [3:0] mism;
    int nbad, cyc, first, exp_w2;
    bit vec_ok;
    tt = t;
    mism = t ^ GOOD_TT;
    nbad = 0;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (mism[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    nbad = nbad * NPASS;
    exp_w2 = (nbad > 3) ? 3 : nbad;

    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    chk({tag, "_start_clear"}, {busy0, done0, fs0, err0}, {1'b1, 1'b0, 1'b0, 8'd0});
    cyc = 0;
    vec_ok = 1'b1;
    while (busy0 && cyc < 4 * RUNLEN) begin
      if ({a0, b0} != 2'((cyc / (HOLD + 1)) % 4) || {a1, b1} != {a0, b0}) vec_ok = 1'b0;
      cyc++;
      tick();
    end
    chk({tag, "_vec_order"}, 32'(vec_ok), 32'd1);
    chk({tag, "_len"}, 32'(cyc), 32'(RUNLEN));
    chk({tag, "_done"}, {done0, busy0, a0, b0}, 4'b1000);
    chk({tag, "_pass"}, 32'(pass0), 32'(nbad == 0));
    chk({tag, "_err"}, 32'(err0), 32'(nbad));
    chk({tag, "_fail_seen"}, 32'(fs0), 32'(nbad != 0));
    chk({tag, "_fail_vec"}, 32'(fv0), (first < 0) ? 32'd0 : 32'(first));
    chk({tag, "_w2_err_sat"}, 32'(err1), 32'(exp_w2));
    chk({tag, "_w2_pass"}, {done1, pass1}, {1'b1, 1'(nbad == 0)});
    start = 1'b0;
    // Results must hold while idle in DONE.
    tick();
    tick();
    chk({tag, "_hold"}, {done0, pass0, err0, fs0}, {1'b1, 1'(nbad == 0), 8'(nbad), 1'(nbad != 0)});
  endtask

  initial begin
    logic [3:0] rt;
    int cyc;
    // Reset state.
    #2;
    chk_idle_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("idle");

    run(GOOD_TT, 1'b0, "good");
    run(4'b1000, 1'b0, "and");        // y = a & b
    run(GOOD_TT, 1'b0, "restart");    // restart from DONE clears faulty result
    run(4'b1111, 1'b0, "stuck1");
    run(4'b1000, 1'b1, "hold_start"); // start held high through the run

    // Reset during the third vector's DRIVE phase.
    tt = GOOD_TT;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 2 * (HOLD + 1) + 1) begin
      cyc++;
      tick();
    end
    chk("third_vec", 32'({a0, b0}), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("post_rst");
    run(GOOD_TT, 1'b0, "after_rst");

    // Randomised fault truth tables.
    for (int k = 0; k < 6; k++) begin
      rt = 4'($urandom);
      run(rt, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de_morgan_checker.md
Name: de_morgan_checker

Overview:
- Self-checking stimulus/response engine for the two-input De Morgan blocks (first law, form b: y = ~a | ~b).
- Drives a and b into a combinational DUT and samples the DUT's y.
- Compares y against the expected value of ~(a & b) and accumulates mismatches.
- Runs on-chip, so the board flags pass/fail without a simulator.

Parameters:
- HOLD_CYCLES, 4: cycles each vector is held before sampling; minimum 1.
- PASSES, 2: number of full sweeps over the 4 input vectors; minimum 1.
- CNT_W, 8: width of the error counter.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level-sampled run request; acted on only in IDLE or DONE.
- a, output, 1: stimulus to DUT input a (MSB of vector).
- b, output, 1: stimulus to DUT input b (LSB of vector).
- y, input, 1: DUT response.
- busy, output, 1: high in DRIVE and SAMPLE.
- done, output, 1: high in DONE.
- pass, output, 1: valid when done is high; 1 if err_cnt == 0.
- err_cnt, output, CNT_W: saturating mismatch count.
- fail_seen, output, 1: at least one mismatch recorded this run.
- fail_vec, output, 2: {a,b} of the first mismatch this run.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - a, b, busy, done, pass, err_cnt, fail_seen and fail_vec are all 0.
  - Internal vector, hold and pass counters are 0.
  - A reset mid-run aborts immediately. There is no partial result.
- States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - a = b = 0.
  - start = 1 moves to DRIVE. On that edge: vector = 00, hold = 0, pass_idx = 0, err_cnt = 0, fail_seen = 0, fail_vec = 0.
- DRIVE:
  - {a,b} = vector, held stable.
  - hold increments each cycle.
  - When hold == HOLD_CYCLES-1, go to SAMPLE next cycle.
- SAMPLE (exactly 1 cycle):
  - {a,b} is unchanged. exp = ~(a & b).
  - If y != exp:
    - err_cnt increments, saturating at 2^CNT_W - 1.
    - If fail_seen == 0, fail_vec = {a,b} and fail_seen = 1.
  - If vector == 3 and pass_idx == PASSES-1, go to DONE.
  - Otherwise vector = vector + 1 mod 4. On wrap 3 -> 0, pass_idx increments. hold = 0, return to DRIVE.
- Vector order within a pass: 00, 01, 10, 11. b toggles fastest.
- DONE:
  - done = 1. pass = (err_cnt == 0). a = b = 0.
  - err_cnt, fail_seen and fail_vec hold their values.
  - start = 1 restarts exactly as from IDLE, including clearing the results.
- start is ignored while busy = 1.
- Timing:
  - The first vector appears on a,b one cycle after start is sampled.
  - Run length is PASSES*4*(HOLD_CYCLES+1) cycles from the first DRIVE cycle to the first DONE cycle. This is 40 with defaults.
- y is assumed combinational from a,b. Holding each vector for HOLD_CYCLES gives settling margin. No synchronizer is placed on y.

Test Plan:
- Correct DUT (y = ~a | ~b), defaults, pulse start -> busy for 40 cycles, then done = 1, pass = 1, err_cnt = 0, fail_seen = 0.
- DUT replaced by y = a & b -> all 4 vectors mismatch each pass. Result: err_cnt = 8, fail_vec = 00, fail_seen = 1, pass = 0.
- y stuck at 1 -> mismatch only at vector 11. Result: err_cnt = 2, fail_vec = 11, pass = 0.
- CNT_W = 2 with y = a & b -> err_cnt saturates at 3 and does not wrap. pass = 0.
- rst_n low for 1 cycle during the third DRIVE vector -> all outputs 0 at once, state IDLE. A new start gives a full clean 40-cycle run.
- start held high during busy -> no restart and length still 40. start in DONE after a faulty run -> err_cnt clears to 0 on restart, and a correct DUT then yields pass = 1.
